// File: rtl/boot_soc_pkg.sv
// boot_soc_pkg: constants shared across the boot SoC slice.
// AXI response codes, imem read FSM encodings, write-hold bundle.
package boot_soc_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_WAIT  = 2'd1,
    R_VALID = 2'd2
  } rd_state_e;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_hold_t;

endpackage

// File: rtl/imem_tdp_ram.sv
// imem_tdp_ram: true dual-port BRAM, 32-bit words.
// Port A byte-write read-first, port B read-only.
module imem_tdp_ram #(
  parameter int    DEPTH     = 4096,
  parameter int    AW        = $clog2(DEPTH),
  parameter string INIT_FILE = ""
) (
  input  logic          clk,
  input  logic          a_en,
  input  logic [3:0]    a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [31:0]   a_wdata,
  output logic [31:0]   a_rdata,
  input  logic          b_en,
  input  logic [AW-1:0] b_addr,
  output logic [31:0]   b_rdata
);

  logic [31:0] mem [DEPTH];

  // Port A read samples the pre-write word.
  always_ff @(posedge clk) begin
    if (a_en) begin
      a_rdata <= mem[a_addr];
      for (int b = 0; b < 4; b++) begin
        if (a_we[b]) mem[a_addr][8*b +: 8] <= a_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (b_en) b_rdata <= mem[b_addr];
  end

endmodule

// File: rtl/axi_lite_imem_slave.sv
// axi_lite_imem_slave: AXI4-Lite window onto the imem BRAM
// plus a native read-only fetch port for the core.
module axi_lite_imem_slave
  import boot_soc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter string       INIT_FILE   = ""
) (
  input  logic        s_axi_aclk,
  input  logic        s_axi_areset,
  input  logic [31:0] s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [31:0] s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic [31:0] fetch_rdata,
  output logic        fetch_rvalid
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [33:0] LIMIT = 34'(DEPTH_WORDS) << 2;

  // Offset wraps mod 2^32, so addresses below the base land out of range.
  function automatic logic in_win(input logic [31:0] a);
    return {2'b00, a - BASE_ADDR} < LIMIT;
  endfunction

  function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
    return AW'((a - BASE_ADDR) >> 2);
  endfunction

  logic        aw_hold;
  logic        w_hold;
  logic [31:0] aw_addr_q;
  wr_hold_t    w_q;
  logic        bvalid_q;
  logic [1:0]  bresp_q;
  logic        aw_hs;
  logic        w_hs;
  logic        ar_hs;
  logic        wr_fire;
  logic        wr_in;

  rd_state_e   state_q;
  rd_state_e   state_d;
  logic        rd_in_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;

  logic        fetch_rvalid_q;
  logic        fetch_in_q;

  logic          ram_a_en;
  logic [3:0]    ram_a_we;
  logic [AW-1:0] ram_a_addr;
  logic [31:0]   ram_a_rdata;
  logic [31:0]   ram_b_rdata;

  assign s_axi_awready = !s_axi_areset & !aw_hold & !bvalid_q;
  assign s_axi_wready  = !s_axi_areset & !w_hold & !bvalid_q;

  assign aw_hs   = s_axi_awvalid & s_axi_awready;
  assign w_hs    = s_axi_wvalid & s_axi_wready;
  assign ar_hs   = s_axi_arvalid & s_axi_arready;
  assign wr_fire = !s_axi_areset & aw_hold & w_hold & !bvalid_q;
  assign wr_in   = in_win(aw_addr_q);

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      aw_hold   <= 1'b0;
      w_hold    <= 1'b0;
      aw_addr_q <= '0;
      w_q       <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= AXI_RESP_OKAY;
    end else begin
      if (aw_hs) begin
        aw_hold   <= 1'b1;
        aw_addr_q <= s_axi_awaddr;
      end
      if (w_hs) begin
        w_hold   <= 1'b1;
        w_q.data <= s_axi_wdata;
        w_q.strb <= s_axi_wstrb;
      end
      if (wr_fire) begin
        aw_hold  <= 1'b0;
        w_hold   <= 1'b0;
        bvalid_q <= 1'b1;
        bresp_q  <= wr_in ? AXI_RESP_OKAY
                          : AXI_RESP_SLVERR;
      end else if (bvalid_q && s_axi_bready) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  assign s_axi_bvalid = bvalid_q;
  assign s_axi_bresp  = bresp_q;

  // Port A is shared; arready is masked while a write fires.
  always_comb begin
    ram_a_en   = wr_fire | ar_hs;
    ram_a_addr = word_idx(s_axi_araddr);
    ram_a_we   = '0;
    unique case (1'b1)
      wr_fire: begin
        ram_a_addr = word_idx(aw_addr_q);
        ram_a_we   = wr_in ? w_q.strb : 4'b0000;
      end
      default: ;
    endcase
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) state_q <= R_IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      R_IDLE:  if (ar_hs) state_d = R_WAIT;
      R_WAIT:  state_d = R_VALID;
      R_VALID: if (s_axi_rready) state_d = R_IDLE;
      default: state_d = R_IDLE;
    endcase
  end

  always_comb begin
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    unique case (state_q)
      R_IDLE:  s_axi_arready = !s_axi_areset & !wr_fire;
      R_VALID: s_axi_rvalid  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      rd_in_q <= 1'b0;
      rdata_q <= '0;
      rresp_q <= AXI_RESP_OKAY;
    end else begin
      if (ar_hs) rd_in_q <= in_win(s_axi_araddr);
      if (state_q == R_WAIT) begin
        rdata_q <= rd_in_q ? ram_a_rdata : 32'h0;
        rresp_q <= rd_in_q ? AXI_RESP_OKAY
                           : AXI_RESP_SLVERR;
      end
    end
  end

  assign s_axi_rdata = rdata_q;
  assign s_axi_rresp = rresp_q;

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      fetch_rvalid_q <= 1'b0;
      fetch_in_q     <= 1'b0;
    end else begin
      fetch_rvalid_q <= fetch_req;
      if (fetch_req) fetch_in_q <= in_win(fetch_addr);
    end
  end

  assign fetch_rvalid = fetch_rvalid_q;
  assign fetch_rdata  = fetch_in_q ? ram_b_rdata : 32'h0;

  imem_tdp_ram #(
    .DEPTH     (DEPTH_WORDS),
    .AW        (AW),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk     (s_axi_aclk),
    .a_en    (ram_a_en),
    .a_we    (ram_a_we),
    .a_addr  (ram_a_addr),
    .a_wdata (w_q.data),
    .a_rdata (ram_a_rdata),
    .b_en    (fetch_req),
    .b_addr  (word_idx(fetch_addr)),
    .b_rdata (ram_b_rdata)
  );

endmodule

// File: tb/tb_axi_lite_imem_slave.sv
// tb_axi_lite_imem_slave: directed bench with a word-level
// memory model and a per-cycle output compare process.
module tb_axi_lite_imem_slave;

  localparam int          DEPTH = 4096;
  localparam logic [31:0] BASE  = 32'h0;

  logic        clk;
  logic        areset;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic [31:0] fetch_rdata;
  logic        fetch_rvalid;

  axi_lite_imem_slave #(
    .BASE_ADDR   (BASE),
    .DEPTH_WORDS (DEPTH),
    .INIT_FILE   ("")
  ) dut (
    .s_axi_aclk    (clk),
    .s_axi_areset  (areset),
    .s_axi_awaddr  (awaddr),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_araddr  (araddr),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready),
    .fetch_req     (fetch_req),
    .fetch_addr    (fetch_addr),
    .fetch_rdata   (fetch_rdata),
    .fetch_rvalid  (fetch_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } rexp_t;

  logic [31:0] model [DEPTH];
  rexp_t       exp_r [$];
  logic [1:0]  exp_b [$];
  logic [31:0] exp_f [$];
  logic        pend_f = 1'b0;
  logic [31:0] side_obs;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic miss(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: output valid with nothing expected at %0t",
             nm, $time);
  endtask

  function automatic bit m_in(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return off < 32'(DEPTH * 4);
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((a - BASE) >> 2) % DEPTH;
  endfunction

  function automatic rexp_t m_read(input logic [31:0] a);
    rexp_t e;
    e.data = m_in(a) ? model[m_idx(a)] : 32'h0;
    e.resp = m_in(a) ? 2'b00 : 2'b10;
    return e;
  endfunction

  task automatic m_write(input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
    if (m_in(a)) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) model[m_idx(a)][8*b +: 8] = d[8*b +: 8];
    end
    exp_b.push_back(m_in(a) ? 2'b00 : 2'b10);
  endtask

  always @(negedge clk) begin
    if (areset) begin
      chk("rst_awready", awready, 0);
      chk("rst_wready", wready, 0);
      chk("rst_arready", arready, 0);
    end
    chk("fetch_rvalid", fetch_rvalid, pend_f);
    if (pend_f) begin
      if (exp_f.size() == 0) miss("fetch");
      else chk("fetch_rdata", fetch_rdata, exp_f.pop_front());
    end
    pend_f = fetch_req && !areset;
    if (bvalid) begin
      chk("b_blocks_aw", awready, 0);
      chk("b_blocks_w", wready, 0);
      if (exp_b.size() == 0) miss("bvalid");
      else begin
        chk("bresp", bresp, exp_b[0]);
        if (bready) void'(exp_b.pop_front());
      end
    end
    if (rvalid) begin
      chk("r_blocks_ar", arready, 0);
      if (exp_r.size() == 0) miss("rvalid");
      else begin
        chk("rdata", rdata, exp_r[0].data);
        chk("rresp", rresp, exp_r[0].resp);
        if (rready) void'(exp_r.pop_front());
      end
    end
    if (areset) begin
      exp_b.delete();
      exp_r.delete();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_aw(input logic [31:0] a);
    int n = 0;
    awaddr  = a;
    awvalid = 1'b1;
    @(negedge clk);
    while (!awready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("aw_handshake", awready, 1);
    tick();
    awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    wdata  = d;
    wstrb  = s;
    wvalid = 1'b1;
    @(negedge clk);
    while (!wready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("w_handshake", wready, 1);
    tick();
    wvalid = 1'b0;
  endtask

  task automatic wait_b(input string nm);
    int lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bvalid && lat < 20);
    chk(nm, lat, 2);
  endtask

  // side 1: AR in the wr_fire cycle; side 2: fetch in that cycle
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int side,
                           input logic [31:0] sa,
                           output logic [1:0] resp);
    int n = 0;
    int lat = 0;
    logic [31:0] old_side;
    old_side = model[m_idx(sa)];
    m_write(a, d, s);
    awaddr  = a;
    wdata   = d;
    wstrb   = s;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    @(negedge clk);
    while (!(awready && wready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("aw_w_handshake", awready && wready, 1);
    tick();
    awvalid = 1'b0;
    wvalid  = 1'b0;
    if (side == 1) begin
      araddr  = sa;
      arvalid = 1'b1;
      exp_r.push_back(m_read(sa));
    end
    if (side == 2) begin
      fetch_addr = sa;
      fetch_req  = 1'b1;
      exp_f.push_back(old_side);
    end
    forever begin
      bit done;
      @(negedge clk);
      lat++;
      done = bvalid || lat >= 20;
      if (side == 1 && lat == 1)
        chk("ar_blocked_by_write", arready, 0);
      if (side == 1 && bvalid)
        chk("ar_after_write", arready, 1);
      if (side == 2 && lat == 2) side_obs = fetch_rdata;
      if (side == 2 && lat == 1) begin
        tick();
        fetch_req = 1'b0;
      end
      if (done) break;
    end
    chk("b_latency", lat, 2);
    resp = bresp;
    tick();
    arvalid = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] a,
                          output logic [31:0] d,
                          output logic [1:0] resp);
    int n = 0;
    int lat = 0;
    exp_r.push_back(m_read(a));
    araddr  = a;
    arvalid = 1'b1;
    @(negedge clk);
    while (!arready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ar_handshake", arready, 1);
    tick();
    arvalid = 1'b0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rvalid && lat < 20);
    chk("r_latency", lat, 2);
    d    = rdata;
    resp = rresp;
    tick();
  endtask

  task automatic fetch(input logic [31:0] a, output logic [31:0] d);
    exp_f.push_back(m_read(a).data);
    fetch_addr = a;
    fetch_req  = 1'b1;
    tick();
    fetch_req = 1'b0;
    @(negedge clk);
    d = fetch_rdata;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, n_bad=%0d", n_bad);
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  rsp;
    int          n;
    areset = 1'b1;
    awaddr = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b1;
    araddr = '0; arvalid = 1'b0;
    rready = 1'b1;
    fetch_req = 1'b0; fetch_addr = '0;
    side_obs = '0;
    repeat (3) tick();
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_rresp", rresp, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_fetch_rvalid", fetch_rvalid, 0);
    chk("rst_fetch_rdata", fetch_rdata, 0);
    areset = 1'b0;
    @(negedge clk);
    chk("awready_after_rst", awready, 1);
    chk("arready_after_rst", arready, 1);
    tick();

    // 1: AW and W together, then read back
    axi_write(32'h10, 32'hDEAD_BEEF, 4'hF, 0, 32'h0, rsp);
    chk("t1_bresp", rsp, 2'b00);
    axi_read(32'h10, d, rsp);
    chk("t1_rdata", d, 32'hDEAD_BEEF);
    chk("t1_rresp", rsp, 2'b00);

    // 2: W first, AW three cycles later, bready held low
    bready = 1'b0;
    m_write(32'h14, 32'hCAFE_F00D, 4'hF);
    send_w(32'hCAFE_F00D, 4'hF);
    repeat (2) begin
      @(negedge clk);
      chk("t2_no_early_b", bvalid, 0);
      tick();
    end
    send_aw(32'h14);
    wait_b("t2_b_latency");
    tick();
    m_write(32'h18, 32'h0BAD_F00D, 4'hF);
    awaddr = 32'h18; wdata = 32'h0BAD_F00D; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_bvalid_hold", bvalid, 1);
      chk("t2_awready_hold", awready, 0);
      chk("t2_wready_hold", wready, 0);
      tick();
    end
    bready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!(awready && wready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t2_second_accept", awready && wready, 1);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    wait_b("t2_b2_latency");
    tick();
    axi_read(32'h14, d, rsp);
    chk("t2_rdata14", d, 32'hCAFE_F00D);
    axi_read(32'h18, d, rsp);
    chk("t2_rdata18", d, 32'h0BAD_F00D);

    // 3: byte strobes
    axi_write(32'h20, 32'h1122_3344, 4'hF, 0, 32'h0, rsp);
    axi_write(32'h20, 32'hAABB_CCDD, 4'b0101, 0, 32'h0, rsp);
    axi_read(32'h20, d, rsp);
    chk("t3_merge", d, 32'h11BB_33DD);

    // 4: out of range, and no aliasing onto word 0
    axi_write(32'h0, 32'h0102_0304, 4'hF, 0, 32'h0, rsp);
    axi_write(32'h4000, 32'hFFFF_FFFF, 4'hF, 0, 32'h0, rsp);
    chk("t4_bresp", rsp, 2'b10);
    axi_read(32'h4000, d, rsp);
    chk("t4_rdata", d, 32'h0);
    chk("t4_rresp", rsp, 2'b10);
    axi_read(32'h0, d, rsp);
    chk("t4_word0_intact", d, 32'h0102_0304);

    // 5: AR collides with wr_fire, rready held low
    rready = 1'b0;
    axi_write(32'h24, 32'h55AA_55AA, 4'hF, 1, 32'h24, rsp);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rvalid && n < 20);
    chk("t5_r_latency", n, 2);
    chk("t5_rdata", rdata, 32'h55AA_55AA);
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      chk("t5_rvalid_hold", rvalid, 1);
      chk("t5_rdata_hold", rdata, 32'h55AA_55AA);
    end
    tick();
    rready = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk);
    chk("t5_rvalid_drop", rvalid, 0);
    tick();

    // 6: fetch port, read-first collision
    fetch(32'h10, d);
    chk("t6_fetch10", d, 32'hDEAD_BEEF);
    fetch(32'h4000, d);
    chk("t6_fetch_oor", d, 32'h0);
    axi_write(32'h0, 32'hA5A5_A5A5, 4'hF, 2, 32'h0, rsp);
    chk("t6_fetch_old", side_obs, 32'h0102_0304);
    fetch(32'h0, d);
    chk("t6_fetch_new", d, 32'hA5A5_A5A5);

    // 7: reset with bvalid high, then an orphaned AW
    axi_write(32'h30, 32'h3030_3030, 4'hF, 0, 32'h0, rsp);
    bready = 1'b0;
    axi_write(32'h2C, 32'h1234_5678, 4'hF, 0, 32'h0, rsp);
    areset = 1'b1;
    @(negedge clk);
    chk("t7_bvalid_pre", bvalid, 1);
    tick();
    chk("t7_bvalid_rst", bvalid, 0);
    areset = 1'b0;
    bready = 1'b1;
    tick();
    send_aw(32'h30);
    areset = 1'b1;
    tick();
    areset = 1'b0;
    send_w(32'h0000_0055, 4'hF);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t7_no_orphan_b", bvalid, 0);
      tick();
    end
    m_write(32'h34, 32'h0000_0055, 4'hF);
    send_aw(32'h34);
    wait_b("t7_b_latency");
    tick();
    axi_read(32'h34, d, rsp);
    chk("t7_rdata34", d, 32'h0000_0055);
    axi_read(32'h30, d, rsp);
    chk("t7_rdata30", d, 32'h3030_3030);

    repeat (3) tick();
    chk("drain_b", exp_b.size(), 0);
    chk("drain_r", exp_r.size(), 0);
    chk("drain_f", exp_f.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
